// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   2-read/1-write register file with a per-register busy (scoreboard) bit.
//   Issue logic reserves a destination (rsv_*), writeback writes data and
//   clears the reservation (reg_write_*). Read ports return data plus busy so
//   the hazard unit can stall on pending producers.
// Ports
//   clock, Reset                 rising-edge clock, async active-low reset
//   read_register_n -> read_data_n / read_busy_n   combinational read ports
//   reg_write_enable/address, write_data           writeback port
//   rsv_enable/address                             reserve port
//   busy_vec                     all busy bits, bit i = register i
//   rsv_conflict                 registered pulse: reserve hit a busy register
module regfile_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clock,
  input  logic                     Reset,
  input  logic [ADDR_W-1:0]        read_register_1,
  input  logic [ADDR_W-1:0]        read_register_2,
  output logic [DATA_W-1:0]        read_data_1,
  output logic [DATA_W-1:0]        read_data_2,
  output logic                     read_busy_1,
  output logic                     read_busy_2,
  input  logic                     reg_write_enable,
  input  logic [ADDR_W-1:0]        reg_write_address,
  input  logic [DATA_W-1:0]        write_data,
  input  logic                     rsv_enable,
  input  logic [ADDR_W-1:0]        rsv_address,
  output logic [(1<<ADDR_W)-1:0]   busy_vec,
  output logic                     rsv_conflict
);
  localparam int NREG  = 1 << ADDR_W;
  localparam int NPORT = 2;

  logic [NREG-1:0][DATA_W-1:0] regs_q, regs_d;
  logic [NREG-1:0]             busy_q, busy_d;
  logic                        conf_q, conf_d;

  // Accesses to a hardwired r0 are dropped here so nothing downstream
  // needs its own r0 special case.
  logic we_eff, rsv_eff;
  assign we_eff  = reg_write_enable && !(ZERO_REG != 0 && reg_write_address == '0);
  assign rsv_eff = rsv_enable       && !(ZERO_REG != 0 && rsv_address       == '0);

  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    // Conflict only if the register stays busy: a same-cycle write retiring
    // the old producer means the new reservation is clean.
    conf_d = rsv_eff && busy_q[rsv_address] &&
             !(we_eff && reg_write_address == rsv_address);
    if (we_eff) begin
      regs_d[reg_write_address] = write_data;
      busy_d[reg_write_address] = 1'b0;
    end
    // Reserve applied after write: the new producer wins on a same-address hit.
    if (rsv_eff) busy_d[rsv_address] = 1'b1;
  end

  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      regs_q <= '0;
      busy_q <= '0;
      conf_q <= 1'b0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
      conf_q <= conf_d;
    end
  end

  // Read ports
  logic [NPORT-1:0][ADDR_W-1:0] rd_addr;
  logic [NPORT-1:0][DATA_W-1:0] rd_data;
  logic [NPORT-1:0]             rd_busy;

  assign rd_addr = {read_register_2, read_register_1};

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int p = 0; p < NPORT; p++) begin
      rd_data[p] = regs_q[rd_addr[p]];
      rd_busy[p] = busy_q[rd_addr[p]];
      // we_eff already excludes a hardwired r0, so r0 never picks up a bypass.
      if (BYPASS != 0 && we_eff && reg_write_address == rd_addr[p]) begin
        rd_data[p] = write_data;
        rd_busy[p] = 1'b0;
      end
      // Block the bypass path from leaking write_data while reset is held.
      if (!Reset) begin
        rd_data[p] = '0;
        rd_busy[p] = 1'b0;
      end
    end
  end

  assign read_data_1  = rd_data[0];
  assign read_data_2  = rd_data[1];
  assign read_busy_1  = rd_busy[0];
  assign read_busy_2  = rd_busy[1];
  assign busy_vec     = busy_q;
  assign rsv_conflict = conf_q;

endmodule
